ro_puf_eval: RTL and testbench
==============================

RO_PUF_EVAL -- requirements
Module: ro_puf_eval

Interface
REQ-001 Parameter NUM_RO, default 8, number of ring-oscillator inputs (2..32).
REQ-002 Parameter CNT_W, default 16, edge-counter width.
REQ-003 Parameter GATE_W, default 16, gate-window length field width.
REQ-004 Parameter RESP_BITS, default 8, response bits per challenge.
REQ-005 clk  input  1  system clock; one clock domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ena  input  1  block enable; low aborts to IDLE.
REQ-008 ro_in  input  NUM_RO  raw oscillator outputs, asynchronous to clk.
REQ-009 start  input  1  evaluation request pulse or level.
REQ-010 chal_a, chal_b  input  SEL_W each (SEL_W = clog2(NUM_RO))  base oscillator indices.
REQ-011 gate_cycles  input  GATE_W  measurement window in clk cycles.
REQ-012 busy  output  1  high from accepted start until the DONE state is left.
REQ-013 resp  output  RESP_BITS  PUF response; resp_valid  output  1; resp_ready  input  1.
REQ-014 err  output  1  challenge rejected; tie  output  1  at least one equal-count pair.
REQ-015 min_margin  output  CNT_W  smallest |cnt_a-cnt_b| over the challenge.

Function
REQ-016 Each ro_in bit SHALL pass a 2-flop synchronizer; counting uses only synchronized values.
REQ-017 States: IDLE, CLEAR, MEASURE, COMPARE, DONE.
REQ-018 IDLE->CLEAR when ena=1 and start=1; chal_a, chal_b and gate_cycles SHALL be latched on that edge.
REQ-019 If chal_a==chal_b, or either index >= NUM_RO, or gate_cycles==0: stay IDLE, pulse err for 1 cycle, no measurement.
REQ-020 Pair k (k=0..RESP_BITS-1) SHALL select RO a=(chal_a+k) mod NUM_RO, b=(chal_b+k) mod NUM_RO.
REQ-021 CLEAR (1 cycle): counters zeroed; edge-detect history loaded with the current selected synchronized values, so a selection change creates no edge.
REQ-022 MEASURE: exactly gate_cycles cycles; each counter increments on a synchronized 0->1 transition, saturating at 2^CNT_W-1.
REQ-023 COMPARE (1 cycle): resp[k] = (cnt_a > cnt_b); equal counts give bit 0 and set tie; min_margin updated with min(current, |cnt_a-cnt_b|).
REQ-024 After COMPARE: k<RESP_BITS-1 -> CLEAR with k+1; else -> DONE.
REQ-025 Latency start-accept to resp_valid = RESP_BITS*(gate_cycles+2)+1 cycles.
REQ-026 DONE: resp_valid=1, resp/tie/min_margin stable; leave to IDLE on the cycle resp_ready=1; start ignored while not IDLE.
REQ-027 tie and min_margin SHALL be reinitialised (0 and all-ones) on each accepted start.
REQ-028 ena=0 in any non-IDLE state: next state IDLE, resp_valid never asserted, resp retains previous value.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, k=0, counters 0, synchronizers 0, resp=0, resp_valid=0, busy=0, err=0, tie=0, min_margin=all-ones.
REQ-030 Reset mid-measurement SHALL discard the partial response; release needs a new start.

Structure
REQ-031 Package ro_puf_pkg SHALL hold the state enum and the clog2-based SEL_W helper.
REQ-032 Sub-module ro_edge_counter (edge detect, clear/load, saturating count) SHALL be instantiated twice, fed by a synchronized-value mux.
REQ-033 No combinational loops inside ro_puf_eval; oscillators live outside it.

Verification
REQ-034 NUM_RO=8, RO3 period 4 clk, RO5 period 8 clk, chal_a=3, chal_b=5, gate=64, RESP_BITS=1 -> cnt 16 vs 8, resp=1, min_margin=8, resp_valid at cycle 67.
REQ-035 Same pair swapped (chal_a=5, chal_b=3) -> resp=0, tie=0.
REQ-036 Two ROs with identical period 6 clk, gate=60 -> resp bit 0, tie=1, min_margin=0.
REQ-037 chal_a=chal_b=2, or gate_cycles=0 -> err pulse 1 cycle, busy stays 0.
REQ-038 RESP_BITS=8, chal_a=6, chal_b=7 -> pairs wrap (7,0), (0,1)...; resp matches per-pair model; resp_valid held until resp_ready pulses after 5 stall cycles.
REQ-039 ena dropped, and separately rst_n asserted, mid-MEASURE -> IDLE, no resp_valid, counters 0; saturation check: CNT_W=4, period 2 clk, gate=64 -> cnt=15.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF evaluator.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Width of an oscillator index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one synchronized oscillator stream, saturating at all-ones.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] count
);

  logic hist;

  // Clear preloads the history so a mux selection change is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      hist  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      hist  <= din;
    end else if (en) begin
      hist <= din;
      if (din && !hist && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: measures oscillator pairs over a gate window
// and builds a response word from the count comparisons.
module ro_puf_eval
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = 8,
  parameter int CNT_W     = 16,
  parameter int GATE_W    = 16,
  parameter int RESP_BITS = 8,
  localparam int SEL_W    = sel_w(NUM_RO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_RO-1:0]    ro_in,
  input  logic                 start,
  input  logic [SEL_W-1:0]     chal_a,
  input  logic [SEL_W-1:0]     chal_b,
  input  logic [GATE_W-1:0]    gate_cycles,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 err,
  output logic                 tie,
  output logic [CNT_W-1:0]     min_margin
);

  localparam int KW        = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int IDX_SPACE = 1 << SEL_W;
  localparam logic [KW-1:0]        K_LAST   = KW'(RESP_BITS - 1);
  localparam logic [SEL_W-1:0]     IDX_LAST = SEL_W'(NUM_RO - 1);
  // Bit i set when index i names a real oscillator.
  localparam logic [IDX_SPACE-1:0] IDX_OK   = {IDX_SPACE{1'b1}} >> (IDX_SPACE - NUM_RO);

  state_t state, state_nxt;

  logic [NUM_RO-1:0]    sync1, sync2;
  logic [SEL_W-1:0]     idx_a, idx_b;
  logic [KW-1:0]        k;
  logic [GATE_W-1:0]    gate_q, remain;
  logic [RESP_BITS-1:0] resp_work, resp_bits;
  logic [CNT_W-1:0]     cnt_a, cnt_b, diff;
  logic                 chal_bad, accept, abort, last_pair, a_gt_b;
  logic                 cnt_clear, cnt_en;

  assign chal_bad  = (chal_a == chal_b) || !IDX_OK[chal_a] || !IDX_OK[chal_b] ||
                     (gate_cycles == '0);
  assign accept    = (state == ST_IDLE) && ena && start && !chal_bad;
  assign abort     = (state != ST_IDLE) && !ena;
  assign last_pair = (k == K_LAST);
  assign cnt_clear = (state == ST_CLEAR) || !ena;
  assign cnt_en    = (state == ST_MEASURE);
  assign a_gt_b    = cnt_a > cnt_b;
  assign diff      = a_gt_b ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
  assign busy      = (state != ST_IDLE);
  assign resp_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .din   (sync2[idx_a]),
    .count (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .din   (sync2[idx_b]),
    .count (cnt_b)
  );

  always_comb begin
    resp_bits    = resp_work;
    resp_bits[k] = a_gt_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_CLEAR;
      ST_CLEAR:   state_nxt = ST_MEASURE;
      ST_MEASURE: if (remain == GATE_W'(1)) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = last_pair ? ST_DONE : ST_CLEAR;
      ST_DONE:    if (resp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // The visible response is only updated on the final compare, so an abort leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a      <= '0;
      idx_b      <= '0;
      k          <= '0;
      gate_q     <= '0;
      remain     <= '0;
      resp_work  <= '0;
      resp       <= '0;
      err        <= 1'b0;
      tie        <= 1'b0;
      min_margin <= '1;
    end else begin
      err <= (state == ST_IDLE) && ena && start && chal_bad;
      if (abort) begin
        k <= '0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            idx_a      <= chal_a;
            idx_b      <= chal_b;
            gate_q     <= gate_cycles;
            k          <= '0;
            resp_work  <= '0;
            tie        <= 1'b0;
            min_margin <= '1;
          end
          ST_CLEAR:   remain <= gate_q;
          ST_MEASURE: remain <= remain - GATE_W'(1);
          ST_COMPARE: begin
            resp_work <= resp_bits;
            tie       <= tie | (cnt_a == cnt_b);
            if (diff < min_margin) min_margin <= diff;
            if (last_pair) begin
              resp <= resp_bits;
            end else begin
              k     <= k + KW'(1);
              idx_a <= (idx_a == IDX_LAST) ? '0 : idx_a + SEL_W'(1);
              idx_b <= (idx_b == IDX_LAST) ? '0 : idx_b + SEL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: single-pair table, 8-bit wrapped challenge,
// abort/reset mid-measurement and counter saturation.
module tb_ro_puf_eval;

  typedef struct {
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic [15:0] gate;
    logic        exp_err;
    logic        exp_resp;
    logic        exp_tie;
    logic [15:0] exp_margin;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        resp_ready = 1'b0;
  logic        start1 = 1'b0, start8 = 1'b0, start_s = 1'b0;
  logic [7:0]  ro_in = '0;
  logic [2:0]  chal_a = '0, chal_b = '0;
  logic [15:0] gate_cycles = '0;

  logic        busy1, resp1, valid1, err1, tie1;
  logic [15:0] margin1;
  logic        busy8, valid8, err8, tie8;
  logic [7:0]  resp8;
  logic [15:0] margin8;
  logic        busy_s, resp_s, valid_s, err_s, tie_s;
  logic [3:0]  margin_s;

  int n_cmp = 0;
  int n_fail = 0;
  int tick = 0;
  int ro_period [8] = '{6, 12, 6, 4, 16, 8, 24, 2};
  logic exp_resp_hold = 1'b0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  // Clock-aligned square waves; each RO's period is in clk cycles.
  always @(negedge clk) begin
    tick++;
    for (int i = 0; i < 8; i++)
      ro_in[i] = ((tick % ro_period[i]) < (ro_period[i] / 2));
  end

  ro_puf_eval #(.NUM_RO(8), .CNT_W(16), .GATE_W(16), .RESP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start1),
    .chal_a(chal_a), .chal_b(chal_b), .gate_cycles(gate_cycles),
    .busy(busy1), .resp(resp1), .resp_valid(valid1), .resp_ready(resp_ready),
    .err(err1), .tie(tie1), .min_margin(margin1)
  );

  ro_puf_eval #(.NUM_RO(8), .CNT_W(16), .GATE_W(16), .RESP_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start8),
    .chal_a(chal_a), .chal_b(chal_b), .gate_cycles(gate_cycles),
    .busy(busy8), .resp(resp8), .resp_valid(valid8), .resp_ready(resp_ready),
    .err(err8), .tie(tie8), .min_margin(margin8)
  );

  ro_puf_eval #(.NUM_RO(8), .CNT_W(4), .GATE_W(16), .RESP_BITS(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start_s),
    .chal_a(chal_a), .chal_b(chal_b), .gate_cycles(gate_cycles),
    .busy(busy_s), .resp(resp_s), .resp_valid(valid_s), .resp_ready(resp_ready),
    .err(err_s), .tie(tie_s), .min_margin(margin_s)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ca, input logic [2:0] cb, input logic [15:0] g);
    chal_a      = ca;
    chal_b      = cb;
    gate_cycles = g;
  endtask

  // Edges counted only between consecutive synchronized samples, so a divisor period gives g/p.
  function automatic int model_count(input int p, input int g);
    return (p == 0) ? 0 : g / p;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    applyStimulus(v.ca, v.cb, v.gate);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    if (v.exp_err) begin
      checkOutput($sformatf("v%0d_err", idx), 32'(err1), 32'd1);
      checkOutput($sformatf("v%0d_busy", idx), 32'(busy1), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_err_drop", idx), 32'(err1), 32'd0);
      checkOutput($sformatf("v%0d_busy_idle", idx), 32'(busy1), 32'd0);
    end else begin
      checkOutput($sformatf("v%0d_busy", idx), 32'(busy1), 32'd1);
      lat = int'(v.gate) + 3;
      repeat (lat - 2) @(negedge clk);
      checkOutput($sformatf("v%0d_valid_early", idx), 32'(valid1), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", idx), 32'(valid1), 32'd1);
      checkOutput($sformatf("v%0d_resp", idx), 32'(resp1), 32'(v.exp_resp));
      checkOutput($sformatf("v%0d_tie", idx), 32'(tie1), 32'(v.exp_tie));
      checkOutput($sformatf("v%0d_margin", idx), 32'(margin1), 32'(v.exp_margin));
      exp_resp_hold = v.exp_resp;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput($sformatf("v%0d_valid_drop", idx), 32'(valid1), 32'd0);
      checkOutput($sformatf("v%0d_busy_drop", idx), 32'(busy1), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  m_resp;
    logic        m_tie;
    logic [15:0] m_margin;
    int ca, cb, na, nb, d;
    logic seen;

    vecs[0] = '{3'd3, 3'd5, 16'd64, 1'b0, 1'b1, 1'b0, 16'd8};
    vecs[1] = '{3'd5, 3'd3, 16'd64, 1'b0, 1'b0, 1'b0, 16'd8};
    vecs[2] = '{3'd0, 3'd2, 16'd60, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{3'd2, 3'd2, 16'd16, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{3'd1, 3'd4, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{3'd7, 3'd4, 16'd64, 1'b0, 1'b1, 1'b0, 16'd28};
    vecs[6] = '{3'd3, 3'd1, 16'd48, 1'b0, 1'b1, 1'b0, 16'd8};

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_valid", 32'(valid1), 32'd0);
    checkOutput("rst_err", 32'(err1), 32'd0);
    checkOutput("rst_tie", 32'(tie1), 32'd0);
    checkOutput("rst_resp8", 32'(resp8), 32'd0);
    checkOutput("rst_margin", 32'(margin1), 32'hFFFF);
    checkOutput("rst_cnt_a", 32'(dut.u_cnt_a.count), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // ena dropped mid-measurement
    @(negedge clk);
    applyStimulus(3'd3, 3'd5, 16'd64);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy1), 32'd0);
    checkOutput("abort_valid", 32'(valid1), 32'd0);
    checkOutput("abort_cnt_a", 32'(dut.u_cnt_a.count), 32'd0);
    checkOutput("abort_cnt_b", 32'(dut.u_cnt_b.count), 32'd0);
    checkOutput("abort_resp_hold", 32'(resp1), 32'(exp_resp_hold));
    ena = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid1 || busy1) seen = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(seen), 32'd0);

    // reset mid-measurement
    applyStimulus(3'd3, 3'd5, 16'd64);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", 32'(busy1), 32'd0);
    checkOutput("rstmid_resp", 32'(resp1), 32'd0);
    checkOutput("rstmid_margin", 32'(margin1), 32'hFFFF);
    checkOutput("rstmid_cnt_a", 32'(dut.u_cnt_a.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid1 || busy1) seen = 1'b1;
    end
    checkOutput("rstmid_no_restart", 32'(seen), 32'd0);

    // 8-bit wrapped challenge with a stalled consumer
    ca = 6; cb = 7;
    m_resp = '0; m_tie = 1'b0; m_margin = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      na = model_count(ro_period[(ca + k) % 8], 48);
      nb = model_count(ro_period[(cb + k) % 8], 48);
      m_resp[k] = (na > nb);
      if (na == nb) m_tie = 1'b1;
      d = (na > nb) ? na - nb : nb - na;
      if (d < int'(m_margin)) m_margin = 16'(d);
    end
    @(negedge clk);
    applyStimulus(3'd6, 3'd7, 16'd48);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("r8_busy", 32'(busy8), 32'd1);
    repeat (401 - 2) @(negedge clk);
    checkOutput("r8_valid_early", 32'(valid8), 32'd0);
    @(negedge clk);
    checkOutput("r8_valid", 32'(valid8), 32'd1);
    checkOutput("r8_resp", 32'(resp8), 32'(m_resp));
    checkOutput("r8_tie", 32'(tie8), 32'(m_tie));
    checkOutput("r8_margin", 32'(margin8), 32'(m_margin));
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput($sformatf("r8_stall%0d_valid", s), 32'(valid8), 32'd1);
      checkOutput($sformatf("r8_stall%0d_resp", s), 32'(resp8), 32'(m_resp));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("r8_valid_drop", 32'(valid8), 32'd0);
    checkOutput("r8_busy_drop", 32'(busy8), 32'd0);

    // 4-bit counter saturation: RO7 (32 edges) clamps to 15, RO4 gives 4
    applyStimulus(3'd7, 3'd4, 16'd64);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (67 - 2) @(negedge clk);
    checkOutput("sat_valid_early", 32'(valid_s), 32'd0);
    @(negedge clk);
    checkOutput("sat_valid", 32'(valid_s), 32'd1);
    checkOutput("sat_resp", 32'(resp_s), 32'd1);
    checkOutput("sat_tie", 32'(tie_s), 32'd0);
    checkOutput("sat_margin", 32'(margin_s), 32'd11);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("sat_valid_drop", 32'(valid_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
